crossbar_mac_array: RTL and testbench

Parametrised behavioural model of a ROWS×COLS 1T1R ReRAM crossbar with a valid/ready command port and a multi-cycle MAC engine. Cells are SET/RESET under row/column masks. A MAC walks the selected rows one per cycle and accumulates a per-column popcount. Each column sum is compared against a threshold to give a 1-bit activation. It replaces the fixed 8×8 single-cycle crossbar model in the user area and feeds the downstream digital readout.

---
 rtl/crossbar_pkg.sv | 17 +
 rtl/crossbar_cell_array.sv | 34 +++
 rtl/crossbar_mac_array.sv | 122 ++++++++++++
 tb/tb_crossbar_mac_array.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared encodings for the ReRAM crossbar MAC array.
package crossbar_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_MAC   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/crossbar_cell_array.sv
// ROWS x COLS 1T1R cell storage: masked SET/RESET write, one combinational row read.
module crossbar_cell_array #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_val,
  input  logic [ROWS-1:0]  wr_row_mask,
  input  logic [COLS-1:0]  wr_col_mask,
  input  logic [IDX_W-1:0] rd_row,
  output logic [COLS-1:0]  rd_data
);

  logic [ROWS-1:0][COLS-1:0] cells;

  // Every cell at the intersection of the two masks takes wr_val.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cells <= '0;
    end else if (wr_en) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (wr_row_mask[r] && wr_col_mask[c]) cells[r][c] <= wr_val;
        end
      end
    end
  end

  assign rd_data = cells[rd_row];

endmodule

// File: rtl/crossbar_mac_array.sv
// Crossbar with valid/ready command port and a row-serial MAC engine producing
// per-column popcounts and thresholded activations.
module crossbar_mac_array
  import crossbar_pkg::*;
#(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned SUM_W  = $clog2(ROWS + 1),
  parameter int unsigned THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ROWS-1:0]       cmd_row_mask,
  input  logic [COLS-1:0]       cmd_col_mask,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [COLS*SUM_W-1:0] res_sum,
  output logic [COLS-1:0]       res_bits,
  output logic                  busy
);

  localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e                       state;
  op_e                          op;
  logic [ROWS-1:0]              sh_row;
  logic [COLS-1:0]              sh_col;
  logic [IDX_W-1:0]             idx;
  logic [COLS-1:0][SUM_W-1:0]   acc;
  logic [COLS-1:0][SUM_W-1:0]   acc_next;
  logic [COLS-1:0]              bits_next;
  logic [COLS-1:0]              row_data;
  logic                         wr_en;
  logic                         wr_val;

  assign op     = op_e'(cmd_op);
  assign wr_en  = (state == ST_IDLE) && cmd_valid && ((op == OP_SET) || (op == OP_RESET));
  assign wr_val = (op == OP_SET);

  crossbar_cell_array #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .IDX_W (IDX_W)
  ) u_cells (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_val      (wr_val),
    .wr_row_mask (cmd_row_mask),
    .wr_col_mask (cmd_col_mask),
    .rd_row      (idx),
    .rd_data     (row_data)
  );

  // One row's contribution; the activation is taken from the final sum.
  always_comb begin
    acc_next  = acc;
    bits_next = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      acc_next[c]  = acc[c] + SUM_W'(sh_row[idx] & sh_col[c] & row_data[c]);
      bits_next[c] = (acc_next[c] >= SUM_W'(THRESH));
    end
  end

  assign res_sum = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_bits  <= '0;
      acc       <= '0;
      sh_row    <= '0;
      sh_col    <= '0;
      idx       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && (op == OP_MAC)) begin
            sh_row    <= cmd_row_mask;
            sh_col    <= cmd_col_mask;
            acc       <= '0;
            idx       <= '0;
            state     <= ST_ACCUM;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_ACCUM: begin
          acc <= acc_next;
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(ROWS - 1)) begin
            state     <= ST_DONE;
            res_valid <= 1'b1;
            res_bits  <= bits_next;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            res_bits  <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_mac_array.sv
// Directed bench for crossbar_mac_array: default 8x8 instance plus a 16x4, THRESH=9 instance.
module tb_crossbar_mac_array;
  import crossbar_pkg::*;

  localparam int unsigned R  = 8,  C  = 4 * 2, SW  = 4;
  localparam int unsigned R2 = 16, C2 = 4,     SW2 = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            cmd_valid, cmd_ready, res_valid, res_ready, busy;
  logic [1:0]      cmd_op;
  logic [R-1:0]    cmd_row_mask;
  logic [C-1:0]    cmd_col_mask;
  logic [C*SW-1:0] res_sum;
  logic [C-1:0]    res_bits;

  logic              cmd_valid2, cmd_ready2, res_valid2, res_ready2, busy2;
  logic [1:0]        cmd_op2;
  logic [R2-1:0]     cmd_row_mask2;
  logic [C2-1:0]     cmd_col_mask2;
  logic [C2*SW2-1:0] res_sum2;
  logic [C2-1:0]     res_bits2;

  crossbar_mac_array dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row_mask(cmd_row_mask), .cmd_col_mask(cmd_col_mask), .res_valid(res_valid),
    .res_ready(res_ready), .res_sum(res_sum), .res_bits(res_bits), .busy(busy)
  );

  crossbar_mac_array #(.ROWS(R2), .COLS(C2), .THRESH(9)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op2),
    .cmd_row_mask(cmd_row_mask2), .cmd_col_mask(cmd_col_mask2), .res_valid(res_valid2),
    .res_ready(res_ready2), .res_sum(res_sum2), .res_bits(res_bits2), .busy(busy2)
  );

  // Results of the last mac_do call
  int              m_lat, m_acc;
  logic [C*SW-1:0] m_sum;
  logic [C-1:0]    m_bits;
  bit              m_stable, m_ready_low, m_busy, m_rdy_back, m_vld_after;

  int                m2_lat;
  logic [C2*SW2-1:0] m2_sum;
  logic [C2-1:0]     m2_bits;

  // All tasks start and end at a negedge.
  task automatic drive_wr(input logic [1:0] op, input logic [R-1:0] rm, input logic [C-1:0] cm);
    cmd_valid = 1'b1; cmd_op = op; cmd_row_mask = rm; cmd_col_mask = cm;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
  endtask

  task automatic mac_do(input logic [R-1:0] rm, input logic [C-1:0] cm, input int hold,
                        input bit side_en, input logic [R-1:0] srm, input logic [C-1:0] scm);
    cmd_valid = 1'b1; cmd_op = OP_MAC; cmd_row_mask = rm; cmd_col_mask = cm;
    @(posedge clk);
    m_acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    if (side_en) begin
      cmd_valid = 1'b1; cmd_op = OP_SET; cmd_row_mask = srm; cmd_col_mask = scm;
    end
    m_busy = busy; m_ready_low = 1'b1; m_lat = 0;
    while (!res_valid && m_lat < 40) begin
      if (cmd_ready) m_ready_low = 1'b0;
      @(posedge clk); @(negedge clk);
      m_lat++;
    end
    m_sum = res_sum; m_bits = res_bits; m_stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      if (!res_valid || cmd_ready || res_sum !== m_sum || res_bits !== m_bits) m_stable = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    m_rdy_back = cmd_ready; m_vld_after = res_valid;
    if (side_en) begin
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0; cmd_op = OP_NOP;
    end
  endtask

  task automatic mac2(input logic [R2-1:0] rm, input logic [C2-1:0] cm);
    cmd_valid2 = 1'b1; cmd_op2 = OP_MAC; cmd_row_mask2 = rm; cmd_col_mask2 = cm;
    @(posedge clk); @(negedge clk);
    cmd_valid2 = 1'b0; cmd_op2 = OP_NOP; m2_lat = 0;
    while (!res_valid2 && m2_lat < 60) begin
      @(posedge clk); @(negedge clk);
      m2_lat++;
    end
    m2_sum = res_sum2; m2_bits = res_bits2;
    res_ready2 = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready2 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    tests++; if (res_sum !== '0) begin fails++; $display("FAIL reset_res_sum: got %h want 0", res_sum); end
    tests++; if (res_bits !== '0) begin fails++; $display("FAIL reset_res_bits: got %h want 0", res_bits); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_mac_empty();
    mac_do(8'hFF, 8'hFF, 0, 1'b0, '0, '0);
    tests++; if (m_lat != 8) begin fails++; $display("FAIL empty_latency: got %0d want 8", m_lat); end
    tests++; if (m_sum !== 32'h0) begin fails++; $display("FAIL empty_sum: got %h want 00000000", m_sum); end
    tests++; if (m_bits !== 8'h00) begin fails++; $display("FAIL empty_bits: got %h want 00", m_bits); end
    tests++; if (m_busy !== 1'b1) begin fails++; $display("FAIL accum_busy: got %b want 1", m_busy); end
    tests++; if (m_rdy_back !== 1'b1) begin fails++; $display("FAIL ready_after_hs: got %b want 1", m_rdy_back); end
    tests++; if (m_vld_after !== 1'b0) begin fails++; $display("FAIL valid_after_hs: got %b want 0", m_vld_after); end
  endtask

  task automatic test_set();
    drive_wr(OP_SET, 8'h0F, 8'hFF);
    mac_do(8'hFF, 8'hFF, 0, 1'b0, '0, '0);
    tests++; if (m_sum !== 32'h4444_4444) begin fails++; $display("FAIL set_sum: got %h want 44444444", m_sum); end
    tests++; if (m_bits !== 8'hFF) begin fails++; $display("FAIL set_bits: got %h want ff", m_bits); end
  endtask

  task automatic test_reset_cells();
    drive_wr(OP_RESET, 8'h01, 8'hAA);
    mac_do(8'hFF, 8'hFF, 0, 1'b0, '0, '0);
    tests++; if (m_sum !== 32'h3434_3434) begin fails++; $display("FAIL clr_sum: got %h want 34343434", m_sum); end
    tests++; if (m_bits !== 8'h55) begin fails++; $display("FAIL clr_bits: got %h want 55", m_bits); end
  endtask

  task automatic test_stall();
    mac_do(8'hFF, 8'hFF, 5, 1'b1, 8'hFF, 8'hFF);
    tests++; if (!m_ready_low) begin fails++; $display("FAIL stall_ready_low: got 1 want 0 during ACCUM"); end
    tests++; if (!m_stable) begin fails++; $display("FAIL stall_stable: got changing want held result"); end
    tests++; if (m_sum !== 32'h3434_3434) begin fails++; $display("FAIL stall_sum: got %h want 34343434", m_sum); end
    tests++; if (m_bits !== 8'h55) begin fails++; $display("FAIL stall_bits: got %h want 55", m_bits); end
    tests++; if (m_rdy_back !== 1'b1) begin fails++; $display("FAIL stall_ready_back: got %b want 1", m_rdy_back); end
    mac_do(8'hFF, 8'hFF, 0, 1'b0, '0, '0);
    tests++; if (m_sum !== 32'h8888_8888) begin fails++; $display("FAIL stalled_set_sum: got %h want 88888888", m_sum); end
    tests++; if (m_bits !== 8'hFF) begin fails++; $display("FAIL stalled_set_bits: got %h want ff", m_bits); end
  endtask

  task automatic test_col_mask();
    mac_do(8'hFF, 8'h0F, 0, 1'b0, '0, '0);
    tests++; if (m_sum !== 32'h0000_8888) begin fails++; $display("FAIL colmask_sum: got %h want 00008888", m_sum); end
    tests++; if (m_bits !== 8'h0F) begin fails++; $display("FAIL colmask_bits: got %h want 0f", m_bits); end
  endtask

  task automatic test_zero_rows();
    mac_do(8'h00, 8'hFF, 0, 1'b0, '0, '0);
    tests++; if (m_lat != 8) begin fails++; $display("FAIL zero_latency: got %0d want 8", m_lat); end
    tests++; if (m_sum !== 32'h0) begin fails++; $display("FAIL zero_sum: got %h want 00000000", m_sum); end
    tests++; if (m_bits !== 8'h00) begin fails++; $display("FAIL zero_bits: got %h want 00", m_bits); end
  endtask

  task automatic test_back_to_back();
    int a1;
    mac_do(8'hFF, 8'hFF, 0, 1'b0, '0, '0);
    a1 = m_acc;
    mac_do(8'hF0, 8'hFF, 0, 1'b0, '0, '0);
    tests++; if (m_acc - a1 != 10) begin fails++; $display("FAIL b2b_spacing: got %0d want 10", m_acc - a1); end
    tests++; if (m_sum !== 32'h4444_4444) begin fails++; $display("FAIL b2b_sum: got %h want 44444444", m_sum); end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    cmd_valid = 1'b1; cmd_op = OP_MAC; cmd_row_mask = 8'hFF; cmd_col_mask = 8'hFF;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL abort_async: got ready=%b busy=%b want 1/0", cmd_ready, busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
    mac_do(8'hFF, 8'hFF, 0, 1'b0, '0, '0);
    tests++; if (m_sum !== 32'h0) begin fails++; $display("FAIL abort_array_clear: got %h want 00000000", m_sum); end
  endtask

  task automatic test_cfg2();
    cmd_valid2 = 1'b1; cmd_op2 = OP_SET; cmd_row_mask2 = 16'hFFFF; cmd_col_mask2 = 4'hF;
    @(posedge clk); @(negedge clk);
    cmd_valid2 = 1'b0; cmd_op2 = OP_NOP;
    mac2(16'hFFFF, 4'hF);
    tests++; if (m2_lat != 16) begin fails++; $display("FAIL cfg2_latency: got %0d want 16", m2_lat); end
    tests++; if (m2_sum !== {4{5'd16}}) begin fails++; $display("FAIL cfg2_full_sum: got %h want %h", m2_sum, {4{5'd16}}); end
    tests++; if (m2_bits !== 4'hF) begin fails++; $display("FAIL cfg2_full_bits: got %h want f", m2_bits); end
    cmd_valid2 = 1'b1; cmd_op2 = OP_RESET; cmd_row_mask2 = 16'h00FF; cmd_col_mask2 = 4'h3;
    @(posedge clk); @(negedge clk);
    cmd_valid2 = 1'b0; cmd_op2 = OP_NOP;
    mac2(16'hFFFF, 4'hF);
    tests++; if (m2_sum !== {5'd16, 5'd16, 5'd8, 5'd8}) begin fails++; $display("FAIL cfg2_part_sum: got %h want %h", m2_sum, {5'd16, 5'd16, 5'd8, 5'd8}); end
    tests++; if (m2_bits !== 4'hC) begin fails++; $display("FAIL cfg2_part_bits: got %h want c", m2_bits); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_row_mask = '0; cmd_col_mask = '0; res_ready = 1'b0;
    cmd_valid2 = 1'b0; cmd_op2 = OP_NOP; cmd_row_mask2 = '0; cmd_col_mask2 = '0; res_ready2 = 1'b0;
    test_reset();
    test_mac_empty();
    test_set();
    test_reset_cells();
    test_stall();
    test_col_mask();
    test_zero_rows();
    test_back_to_back();
    test_reset_abort();
    test_cfg2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
